// File: rtl/test_add_rec_fn.sv
// Binary32 adder with round-to-nearest-even: outputSum = inputA + inputB.
// One registered stage (1-cycle latency, 1 result/cycle), no handshake or backpressure.
module test_add_rec_fn (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    output logic [31:0] outputSum
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [4:0] leadingZeros(input logic [26:0] v);
        leadingZeros = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) leadingZeros = 5'(26 - i);
    endfunction

    logic        signA, signB;
    logic [7:0]  expA, expB;
    logic [22:0] fracA, fracB;
    logic        nanA, nanB, infA, infB;

    assign {signA, expA, fracA} = inputA;
    assign {signB, expB, fracB} = inputB;
    assign nanA = (expA == 8'hFF) && (fracA != 23'd0);
    assign nanB = (expB == 8'hFF) && (fracB != 23'd0);
    assign infA = (expA == 8'hFF) && (fracA == 23'd0);
    assign infB = (expB == 8'hFF) && (fracB == 23'd0);

    logic        swap;
    logic        signBig, signSmall;
    logic [7:0]  expBigRaw, expSmallRaw, expBig, expSmall, expDiff;
    logic [22:0] fracBig, fracSmall;
    logic [26:0] bigExt, smallExt, lostMask, alignedSmall;

    assign swap = {expB, fracB} > {expA, fracA};
    assign {signBig, expBigRaw, fracBig}       = swap ? inputB : inputA;
    assign {signSmall, expSmallRaw, fracSmall} = swap ? inputA : inputB;
    assign expBig   = (expBigRaw == 8'd0) ? 8'd1 : expBigRaw;
    assign expSmall = (expSmallRaw == 8'd0) ? 8'd1 : expSmallRaw;
    assign expDiff  = expBig - expSmall;
    assign bigExt   = {expBigRaw != 8'd0, fracBig, 3'b000};
    assign smallExt = {expSmallRaw != 8'd0, fracSmall, 3'b000};

    // Bits shifted past the round position fold into the sticky LSB.
    assign lostMask = (27'd1 << expDiff[4:0]) - 27'd1;
    assign alignedSmall = (expDiff >= 8'd26) ? {26'd0, |smallExt}
                        : ((smallExt >> expDiff[4:0]) | {26'd0, |(smallExt & lostMask)});

    logic [27:0] rawSum;
    logic [26:0] mag, normMag;
    logic [9:0]  expWork, normExp, finalExp;
    logic [4:0]  lz, normShift;

    assign rawSum = (signBig == signSmall) ? ({1'b0, bigExt} + {1'b0, alignedSmall})
                                           : ({1'b0, bigExt} - {1'b0, alignedSmall});
    assign mag     = rawSum[27] ? {rawSum[27:2], rawSum[1] | rawSum[0]} : rawSum[26:0];
    assign expWork = {2'b00, expBig} + {9'd0, rawSum[27]};

    // Normalization stops at exponent 1 so tiny results stay subnormal.
    assign lz        = leadingZeros(mag);
    assign normShift = ({5'd0, lz} > (expWork - 10'd1)) ? 5'(expWork - 10'd1) : lz;
    assign normMag   = mag << normShift;
    assign normExp   = expWork - {5'd0, normShift};

    logic [23:0] mant, finalMant;
    logic        roundUp;
    logic [24:0] mantRounded;

    assign mant        = normMag[26:3];
    assign roundUp     = normMag[2] & (normMag[1] | normMag[0] | normMag[3]);
    assign mantRounded = {1'b0, mant} + {24'd0, roundUp};
    assign finalMant   = mantRounded[24] ? mantRounded[24:1] : mantRounded[23:0];
    assign finalExp    = normExp + {9'd0, mantRounded[24]};

    logic [31:0] sumNext;

    always_comb begin
        sumNext = 32'd0;
        if (nanA || nanB)
            sumNext = QNAN;
        else if (infA && infB && (signA != signB))
            sumNext = QNAN;
        else if (infA)
            sumNext = inputA;
        else if (infB)
            sumNext = inputB;
        else if (mag == 27'd0)
            sumNext = {signA & signB, 31'd0};
        else if (finalExp >= 10'd255)
            sumNext = {signBig, 8'hFF, 23'd0};
        else
            sumNext = {signBig, finalMant[23] ? finalExp[7:0] : 8'd0, finalMant[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            outputSum <= 32'h00000000;
        else
            outputSum <= sumNext;
    end
endmodule

// File: tb/tb_test_add_rec_fn.sv
// Bench for test_add_rec_fn: directed corner cases plus random operands checked
// against an exact wide-integer reference adder.
module tb_test_add_rec_fn;
    logic        clk;
    logic        rst;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic [31:0] outputSum;

    int checks = 0;
    int errors = 0;

    test_add_rec_fn dut (
        .clk(clk),
        .rst(rst),
        .inputA(inputA),
        .inputB(inputB),
        .outputSum(outputSum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Operand value as a signed integer count of 2^-149 units (exact).
    function automatic logic signed [283:0] toUnits(input logic [31:0] x);
        logic [283:0] v;
        int e;
        e = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        v = 284'({x[30:23] != 8'd0, x[22:0]}) << (e - 1);
        return x[31] ? -$signed(v) : $signed(v);
    endfunction

    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        logic aNan, bNan, aInf, bInf, sgn;
        logic signed [283:0] s;
        logic [283:0] m, mant, rem, half;
        int p, sh, e;
        aNan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bNan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        aInf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bInf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (aNan || bNan) return 32'h7FC00000;
        if (aInf && bInf) return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (aInf) return a;
        if (bInf) return b;
        s = toUnits(a) + toUnits(b);
        if (s == 0) return {a[31] & b[31], 31'd0};
        sgn = s[283];
        m = sgn ? 284'(-s) : 284'(s);
        p = 0;
        for (int i = 0; i < 284; i++)
            if (m[i]) p = i;
        if (p < 23) return {sgn, 8'd0, m[22:0]};
        sh = p - 23;
        mant = m >> sh;
        rem = m & ((284'd1 << sh) - 284'd1);
        if (sh > 0) begin
            half = 284'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 284'd1;
        end
        e = sh + 1;
        if (mant[24]) begin
            mant = mant >> 1;
            e++;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        return {sgn, 8'(e), mant[22:0]};
    endfunction

    task automatic driveCheck(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] want);
        inputA = a;
        inputB = b;
        @(posedge clk);
        #1;
        checkVal(tag, outputSum, want);
    endtask

    logic [31:0] specials [6];
    logic [31:0] ra, rb, want;

    initial begin
        specials[0] = 32'h7F800000; specials[1] = 32'hFF800000;
        specials[2] = 32'h7FC12345; specials[3] = 32'h80000000;
        specials[4] = 32'h00000000; specials[5] = 32'h7F7FFFFF;

        rst = 1'b1;
        inputA = 32'h40200000;
        inputB = 32'h40600000;
        #7;
        checkVal("reset_init", outputSum, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("reset_release_hold", outputSum, 32'h00000000);

        driveCheck("basic_add",      32'h40200000, 32'h40600000, 32'h40C00000);
        driveCheck("cancel_zero",    32'hBF800000, 32'h3F800000, 32'h00000000);
        driveCheck("tie_even",       32'h3F800000, 32'h33800000, 32'h3F800000);
        driveCheck("tie_odd_up",     32'h3F800001, 32'h33800000, 32'h3F800002);
        driveCheck("massive_cancel", 32'h3F800000, 32'hBF7FFFFF, 32'h33800000);
        driveCheck("inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000);
        driveCheck("nan_in",         32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        driveCheck("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        driveCheck("neg_zero",       32'h80000000, 32'h80000000, 32'h80000000);
        driveCheck("pos_neg_zero",   32'h00000000, 32'h80000000, 32'h00000000);
        driveCheck("subn_add",       32'h00000001, 32'h00000001, 32'h00000002);
        driveCheck("subn_to_norm",   32'h007FFFFF, 32'h00000001, 32'h00800000);
        driveCheck("inf_plus_fin",   32'hFF800000, 32'h3F800000, 32'hFF800000);

        // Output must hold while operands change between edges.
        inputA = 32'h3F800000;
        inputB = 32'h3F800000;
        #3;
        checkVal("hold_between_edges", outputSum, 32'hFF800000);
        @(posedge clk);
        #1;
        checkVal("after_hold", outputSum, 32'h40000000);

        // Async reset mid-run with nonzero operands.
        inputA = 32'h40200000;
        inputB = 32'h40600000;
        #1;
        rst = 1'b1;
        #1;
        checkVal("reset_async", outputSum, 32'h00000000);
        @(posedge clk);
        #1;
        checkVal("reset_held_edge", outputSum, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("reset_off_no_edge", outputSum, 32'h00000000);
        @(posedge clk);
        #1;
        checkVal("reset_first_edge", outputSum, 32'h40C00000);

        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                1: rb = {~ra[31], ra[30:23], ra[22:0] ^ 23'($urandom_range(0, 255))};
                2: begin
                    ra[30:23] = 8'($urandom_range(0, 3));
                    rb[30:23] = 8'($urandom_range(0, 3));
                end
                3: rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
                4: ra = specials[$urandom_range(0, 5)];
                default: ;
            endcase
            want = refAdd(ra, rb);
            driveCheck($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, want);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
